// File: rtl/mm_pkg.sv
// Shared constants for the matrix-multiply result path.
// - DATA_W/ADDR_W/CNT_SHIFT: default line width, RAM address width and
//   the shift that turns rows*columns into a line count.
// - FSM state encodings for the drain buffer controller.
package mm_pkg;

    localparam int DATA_W    = 1024;
    localparam int ADDR_W    = 8;
    localparam int CNT_SHIFT = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SETUP = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ram_output2.sv
// Simple dual-port line RAM, 2**ADDR_W x DATA_W, two-cycle read.
// - we_i/waddr_i/wdata_i : synchronous write port
// - re_i/raddr_i         : read request; address is registered on re_i
// - rdata_o              : registered read data, valid two cycles after re_i
// Same-edge read/write of one address returns the old contents.
module ram_output2 #(
    parameter int DATA_W = mm_pkg::DATA_W,
    parameter int ADDR_W = mm_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) raddr_q <= raddr_i;
        rdata_q <= mem_q[raddr_q];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/result_skid_fifo.sv
// Small shift-register FIFO that absorbs RAM read data ahead of the host.
// - push_i/data_i : enqueue (caller guarantees space)
// - pop_i         : dequeue the head when valid_o
// - flush_i       : drop all entries (wins over push/pop)
// - head_o        : entry 0, a plain register so the host sees a flop output
// - valid_o/count_o : occupancy
module result_skid_fifo #(
    parameter int DATA_W = mm_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         pop_i,
    output logic [DATA_W-1:0]            head_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_W-1:0] ent_q, ent_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [CW-1:0]                wr_idx;
    logic                         pop;

    assign pop    = pop_i && (cnt_q != '0);
    // After a same-cycle pop the tail moves down one slot.
    assign wr_idx = cnt_q - CW'(pop);

    always_comb begin
        ent_d = ent_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i + 1];
            ent_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (CW'(i) == wr_idx)) ent_d[i] = data_i;
        end
        cnt_d = cnt_q + CW'(push_i) - CW'(pop);
        if (flush_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = ent_q[0];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/result_drain_buffer.sv
// Result drain buffer: collects result lines from the MM array into a
// circular line RAM and streams them, in order, to the host write channel.
// Ports:
// - clk_i, rst_ni           : clock, asynchronous active-low reset
// - start_i, row_i, column_i: job start pulse and its dimensions ([15:0] used)
// - din_i/din_valid_i/din_ready_o : array-side line input
// - dout_o/dout_valid_o/dout_ack_i: host-side line output
// - done_o     : high once every expected line has been acked
// - overflow_o : sticky, a line was offered while din_ready_o was low
module result_drain_buffer #(
    parameter int DATA_W    = mm_pkg::DATA_W,
    parameter int ADDR_W    = mm_pkg::ADDR_W,
    parameter int CNT_SHIFT = mm_pkg::CNT_SHIFT,
    parameter int RAM_LAT   = 2,
    parameter int SKID_D    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       row_i,
    input  logic [31:0]       column_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ack_i,
    output logic              done_o,
    output logic              overflow_o
);

    import mm_pkg::*;

    localparam int CNT_W = ADDR_W + 1;
    localparam int SK_W  = $clog2(SKID_D + 1);
    localparam int PW    = SK_W + 1;
    localparam logic [CNT_W-1:0] RAM_DEPTH = CNT_W'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [1:0]        setup_cnt_q, setup_cnt_d;
    logic [15:0]       row_q, row_d, col_q, col_d;
    logic [31:0]       prod_q, prod_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [CNT_W-1:0]  wr_lines_q, wr_lines_d, rd_lines_q, rd_lines_d;
    logic              overflow_q, overflow_d;

    // vld_pipe[0] is this cycle's read issue; vld_pipe[RAM_LAT] marks RAM
    // data arriving this cycle.
    logic [RAM_LAT:0]  vld_pipe;
    logic [RAM_LAT:1]  vld_pipe_q;

    logic              wr_acc, rd_issue, skid_pop;
    logic [PW-1:0]     pend;
    logic [SK_W-1:0]   skid_cnt;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_bits;

    assign unused_bits = ^{row_i[31:16], column_i[31:16],
                           prod_q[31:ADDR_W+CNT_SHIFT+1], prod_q[CNT_SHIFT-1:0]};

    assign din_ready_o = (state_q == ST_RUN) && (occ_q < RAM_DEPTH) &&
                         (wr_lines_q < total_q);
    assign wr_acc      = din_valid_i && din_ready_o;
    assign skid_pop    = dout_valid_o && dout_ack_i;

    // Reads are only issued when the skid FIFO is guaranteed room for the
    // data, counting lines still travelling through the RAM pipeline.
    always_comb begin
        pend = PW'(skid_cnt);
        for (int k = 1; k <= RAM_LAT; k++) pend = pend + PW'(vld_pipe_q[k]);
    end

    assign rd_issue = (occ_q != '0) && (pend < PW'(SKID_D));
    assign vld_pipe = {vld_pipe_q, rd_issue};

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        prod_d      = prod_q;
        total_d     = total_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_lines_d  = wr_lines_q;
        rd_lines_d  = rd_lines_q;
        overflow_d  = overflow_q | (din_valid_i & ~din_ready_o);
        occ_d       = occ_q + CNT_W'(wr_acc) - CNT_W'(rd_issue);

        if (wr_acc) begin
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            wr_lines_d = wr_lines_q + CNT_W'(1);
        end
        if (rd_issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        if (skid_pop) rd_lines_d = rd_lines_q + CNT_W'(1);

        case (state_q)
            ST_SETUP: begin
                setup_cnt_d = setup_cnt_q + 2'd1;
                case (setup_cnt_q)
                    2'd0:    prod_d  = {16'd0, row_q} * {16'd0, col_q};
                    2'd1:    total_d = prod_q[ADDR_W+CNT_SHIFT:CNT_SHIFT];
                    default: state_d = (total_q == '0) ? ST_DONE : ST_RUN;
                endcase
            end
            // Looking at the next-state count lets done rise the cycle
            // right after the final ack.
            ST_RUN:  if (rd_lines_d == total_q) state_d = ST_DONE;
            default: ;
        endcase

        // start aborts whatever is running and reinitialises the job.
        if (start_i) begin
            state_d     = ST_SETUP;
            setup_cnt_d = 2'd0;
            row_d       = row_i[15:0];
            col_d       = column_i[15:0];
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            wr_lines_d  = '0;
            rd_lines_d  = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            prod_q      <= '0;
            total_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            wr_lines_q  <= '0;
            rd_lines_q  <= '0;
            overflow_q  <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            prod_q      <= prod_d;
            total_q     <= total_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            wr_lines_q  <= wr_lines_d;
            rd_lines_q  <= rd_lines_d;
            overflow_q  <= overflow_d;
            // In-flight reads are forgotten on abort; their data never
            // reaches the skid FIFO.
            vld_pipe_q  <= start_i ? '0 : vld_pipe[RAM_LAT-1:0];
        end
    end

    ram_output2 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din_i),
        .re_i    (rd_issue),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    result_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (start_i),
        .push_i  (vld_pipe[RAM_LAT]),
        .data_i  (ram_rdata),
        .pop_i   (dout_ack_i),
        .head_o  (dout_o),
        .valid_o (dout_valid_o),
        .count_o (skid_cnt)
    );

    assign done_o     = (state_q == ST_DONE);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_result_drain_buffer.sv
module tb_result_drain_buffer;

    localparam int DW = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [31:0]   row_i = '0;
    logic [31:0]   column_i = '0;
    logic [DW-1:0] din_i = '0;
    logic          din_valid_i = 1'b0;
    logic          din_ready_o;
    logic [DW-1:0] dout_o;
    logic          dout_valid_o;
    logic          dout_ack_i = 1'b0;
    logic          done_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    result_drain_buffer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start_i),
        .row_i        (row_i),
        .column_i     (column_i),
        .din_i        (din_i),
        .din_valid_i  (din_valid_i),
        .din_ready_o  (din_ready_o),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_ack_i   (dout_ack_i),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    int total = 0;
    int bad   = 0;

    // scoreboard of accepted lines and per-job bookkeeping
    logic [DW-1:0] sb[$];
    int sent, got, n_send, exp_n, salt;
    bit poke, poked;

    typedef struct {
        logic [31:0] row;
        logic [31:0] col;
        int          n_send;     // lines offered to the buffer
        int          exp_n;      // hand-computed expected line count
        int          ack_pct;    // host ack probability in percent
        int          stop_sent;  // >0: abandon the job after this many lines
        bit          poke;       // offer one extra line once ready drops
        bit          exp_ovf;    // expected overflow at job end
    } vec_t;

    vec_t tbl[7];

    function automatic logic [DW-1:0] mk(input int idx, input int s);
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = 32'(idx) ^ (32'(w) << 20) ^ 32'(s);
        return v;
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_line(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got low128 %h want low128 %h", nm, act[127:0], exp[127:0]);
        end
    endtask

    task automatic do_start(input logic [31:0] r, input logic [31:0] c, input int s,
                            input int ns, input int en, input bit pk);
        @(negedge clk);
        start_i = 1'b1; row_i = r; column_i = c;
        din_valid_i = 1'b0; dout_ack_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        sb.delete();
        sent = 0; got = 0; salt = s << 24; n_send = ns; exp_n = en; poke = pk; poked = 0;
        chk_bit("flush_dout_valid", dout_valid_o, 1'b0);
        chk_bit("flush_done", done_o, 1'b0);
        chk_bit("flush_overflow", overflow_o, 1'b0);
    endtask

    // One negedge per cycle: check, then drive ack and din for the next edge.
    task automatic pump(input int ack_pct, input int max_cyc, input bit until_done, input int stop_sent);
        logic [DW-1:0] prev = '0;
        bit stalled = 0, ack_last = 0, ack, finished = 0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (ack_last) chk_bit("done_after_last_ack", done_o, 1'b1);
            else if (got < exp_n) chk_bit("done_low_while_pending", done_o, 1'b0);
            if (got >= exp_n) chk_bit("no_valid_after_last", dout_valid_o, 1'b0);
            if (stalled) begin
                chk_bit("valid_held_on_stall", dout_valid_o, 1'b1);
                chk_line("dout_held_on_stall", dout_o, prev);
            end
            if (until_done && done_o && got == exp_n) begin
                finished = 1;
                break;
            end
            ack_last = 0;
            ack = ($urandom_range(99) < ack_pct);
            if (dout_valid_o && ack) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dout_extra: got a line, want none");
                end else begin
                    chk_line("dout_order", dout_o, sb.pop_front());
                end
                got++;
                ack_last = (got == exp_n);
            end
            stalled = dout_valid_o && !ack;
            prev = dout_o;
            dout_ack_i = ack;
            if (sent < n_send && din_ready_o) begin
                din_valid_i = 1'b1;
                din_i = mk(sent, salt);
                sb.push_back(din_i);
                sent++;
            end else if (poke && !poked && sent == n_send && !din_ready_o) begin
                din_valid_i = 1'b1;
                din_i = ~mk(sent, salt);
                poked = 1;
            end else begin
                din_valid_i = 1'b0;
            end
            if (stop_sent > 0 && sent >= stop_sent) begin
                finished = 1;
                break;
            end
        end
        if (!finished && (until_done || stop_sent > 0)) begin
            total++; bad++;
            $display("FAIL pump_timeout: got %0d lines want %0d", got, exp_n);
        end
        if (stop_sent == 0) begin
            din_valid_i = 1'b0;
            dout_ack_i = 1'b0;
        end
    endtask

    task automatic run_vec(input int i);
        do_start(tbl[i].row, tbl[i].col, i + 1, tbl[i].n_send, tbl[i].exp_n, tbl[i].poke);
        pump(tbl[i].ack_pct, 3000, tbl[i].stop_sent == 0, tbl[i].stop_sent);
        if (tbl[i].stop_sent == 0) begin
            chk_int("lines_drained", got, tbl[i].exp_n);
            chk_bit("overflow_end", overflow_o, tbl[i].exp_ovf);
            chk_bit("done_end", done_o, 1'b1);
            @(negedge clk);
            chk_bit("done_holds", done_o, 1'b1);
        end
    endtask

    task automatic check_reset_outputs();
        chk_bit("rst_din_ready", din_ready_o, 1'b0);
        chk_bit("rst_dout_valid", dout_valid_o, 1'b0);
        chk_line("rst_dout", dout_o, '0);
        chk_bit("rst_done", done_o, 1'b0);
        chk_bit("rst_overflow", overflow_o, 1'b0);
    endtask

    initial begin
        //          row            col      send exp ack stop poke ovf
        tbl[0] = '{32'hABCD_0040, 32'd16,   32,  32, 100, 0, 1'b0, 1'b0}; // upper bits ignored
        tbl[1] = '{32'd64,        32'd16,   32,  32, 100, 0, 1'b1, 1'b1}; // overflow poke
        tbl[2] = '{32'd64,        32'd1024, 0,   0,  100, 0, 1'b0, 1'b0}; // 2048 -> field 0
        tbl[3] = '{32'd0,         32'd16,   0,   0,  100, 0, 1'b0, 1'b0}; // row 0
        tbl[4] = '{32'd96,        32'd100,  300, 300, 50, 0, 1'b0, 1'b0}; // wrap, random ack
        tbl[5] = '{32'd96,        32'd100,  300, 300, 100, 10, 1'b0, 1'b0}; // aborted
        tbl[6] = '{32'd64,        32'd16,   32,  32, 70, 0, 1'b0, 1'b0};  // after abort

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("idle_din_ready", din_ready_o, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Back-pressure: no acks until the RAM fills (256) plus a full skid (4).
        do_start(32'd96, 32'd100, 9, 300, 300, 1'b0);
        pump(0, 320, 1'b0, 0);
        chk_int("fill_accepted", sent, 260);
        chk_bit("fill_din_ready_low", din_ready_o, 1'b0);
        chk_bit("fill_dout_valid", dout_valid_o, 1'b1);
        chk_bit("fill_no_overflow", overflow_o, 1'b0);
        pump(100, 3000, 1'b1, 0);
        chk_int("fill_lines_drained", got, 300);
        chk_bit("fill_overflow_end", overflow_o, 1'b0);

        // Reset in the middle of a job, then a clean job.
        do_start(32'd96, 32'd100, 10, 300, 300, 1'b0);
        pump(100, 500, 1'b0, 20);
        @(negedge clk);
        rst_n = 1'b0; din_valid_i = 1'b0; dout_ack_i = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
